conv_line_buffer: RTL and testbench
===================================

Name: conv_line_buffer

Overview:
Parametrised rolling line buffer that feeds the convolution kernel array. Holds KERNEL_SIZE image rows of IMAGE_SIZE pixels each. Rows arrive from the pixel source over a valid/ready stream. A controller drives it with start/next commands and receives one-cycle acknowledge pulses. It is the generalised successor of the fixed 3-row, 8-pixel input cache: kernel depth and row length are configurable, input is flow-controlled, image rows are tracked, and there is an explicit end-of-image flag.

Parameters:
WIDTH, 32, pixel word width in bits
IMAGE_SIZE, 8, pixels per image row and rows per image
KERNEL_SIZE, 3, number of row banks (kernel height), >=2
COL_W, 3, column index width, >= clog2(IMAGE_SIZE)
ROW_W, 4, image row counter width, >= clog2(IMAGE_SIZE+1)
SEL_W, 2, row_sel width, >= clog2(KERNEL_SIZE)
FLOAT32_ONE, 32'h3F800000, bias word

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_start  in  1  begin new image: clear banks, preload KERNEL_SIZE rows
cmd_next  in  1  load one more row, shift window down one row
pixel_in  in  WIDTH  streamed pixel, row-major
pixel_valid  in  1  pixel_in valid
pixel_ready  out  1  buffer accepts a pixel this cycle
row_sel  in  SEL_W  bank selected onto data_out_bus (0 = oldest row)
bias_sel  in  1  forces data_out_bus to IMAGE_SIZE copies of FLOAT32_ONE
data_out_bus  out  IMAGE_SIZE*WIDTH  selected row, pixel 0 in the MS word
window_valid  out  1  all KERNEL_SIZE banks hold a current window
ack_preload_fin  out  1  one-cycle pulse when preload completes
ack_load_fin  out  1  one-cycle pulse when a next-row load completes
image_done  out  1  all IMAGE_SIZE rows of the image have been loaded
busy  out  1  high in PRELOAD or LOAD

Behaviour:
- FSM states: IDLE, PRELOAD, READY, LOAD.
- Reset (async, rst=1) sets state IDLE and clears banks, staging register, col_idx, rows_loaded, img_row, image_done and both acks to 0. All outputs are 0 while bias_sel=0.
- IDLE or READY, cmd_start=1: clear banks, staging, col_idx, rows_loaded, img_row and image_done in the same edge; go to PRELOAD. cmd_start has priority over cmd_next. cmd_start is ignored in PRELOAD and LOAD.
- READY, cmd_next=1, image_done=0: go to LOAD. cmd_next is ignored when image_done=1 (state stays READY, no ack), and in IDLE, PRELOAD and LOAD.
- pixel_ready = busy = (state==PRELOAD || state==LOAD). It is combinational from state only.
- A pixel is accepted when pixel_valid && pixel_ready. Word col_idx of the staging register is written at slice [(IMAGE_SIZE-col_idx)*WIDTH-1 -: WIDTH]. col_idx then increments.
- Row commit happens on an accept with col_idx==IMAGE_SIZE-1. In that same edge:
  - bank[i] <= bank[i+1] for i < KERNEL_SIZE-1;
  - bank[KERNEL_SIZE-1] <= staging with the final pixel merged in;
  - col_idx <= 0 (wraps); img_row increments;
  - if img_row+1 == IMAGE_SIZE, image_done <= 1.
- PRELOAD: rows_loaded increments on each commit. On the commit that makes rows_loaded==KERNEL_SIZE, go to READY and pulse ack_preload_fin on the next cycle.
- LOAD: the first commit goes to READY and pulses ack_load_fin.
- Pixels presented with pixel_valid while pixel_ready=0 are not consumed. The source must hold them.
- window_valid = (state==READY). It is low during LOAD even though the banks are stable until the commit edge.
- data_out_bus is combinational:
  - bias_sel=1: {IMAGE_SIZE{FLOAT32_ONE}};
  - bias_sel=0 and row_sel<KERNEL_SIZE: bank[row_sel];
  - otherwise: 0.
- Bank contents are readable in every state. Mid-row contents of the staging register are never visible on data_out_bus.
- image_done stays high until cmd_start or reset.
- Reset asserted mid-row discards the partial row. No ack is issued.

Test Plan:
- Reset, then IMAGE_SIZE=8, KERNEL_SIZE=3: pixel_ready=0, window_valid=0, data_out_bus=0 for every row_sel, all acks 0.
- cmd_start, stream 24 pixels 32'hRC (R=row, C=col) back-to-back -> ack_preload_fin pulses exactly once, one cycle after pixel 0x27 is accepted. row_sel=0 gives 00,01..07 with 00 in the MS word; row_sel=2 gives 20..27; window_valid=1.
- From READY, cmd_next, stream row 3 with pixel_valid toggling every other cycle -> exactly 8 accepts and ack_load_fin once. Banks then read rows 1,2,3 for row_sel 0,1,2.
- Keep issuing cmd_next until row 7 loads -> image_done=1 on the commit of pixel 0x77, banks hold rows 5,6,7. A further cmd_next is ignored: state stays READY, pixel_ready=0, no ack.
- bias_sel=1 with any row_sel -> 8 x 3F800000; row_sel=3 with bias_sel=0 -> all zero.
- Assert rst after 5 pixels of row 3 in LOAD -> immediate IDLE with all banks 0. A subsequent cmd_start plus 24 pixels preloads cleanly with no stale data.

Source files
------------

// File: rtl/conv_line_buffer.sv
// Rolling K-row line buffer feeding the convolution kernel array.
// Rows stream in over valid/ready; start/next commands roll the window.
module conv_line_buffer #(
  parameter int WIDTH       = 32,
  parameter int IMAGE_SIZE  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int COL_W       = 3,
  parameter int ROW_W       = 4,
  parameter int SEL_W       = 2,
  parameter logic [WIDTH-1:0] FLOAT32_ONE = 32'h3F800000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cmd_start,
  input  logic                        i_cmd_next,
  input  logic [WIDTH-1:0]            i_pixel_in,
  input  logic                        i_pixel_valid,
  output logic                        o_pixel_ready,
  input  logic [SEL_W-1:0]            i_row_sel,
  input  logic                        i_bias_sel,
  output logic [IMAGE_SIZE*WIDTH-1:0] o_data_out_bus,
  output logic                        o_window_valid,
  output logic                        o_ack_preload_fin,
  output logic                        o_ack_load_fin,
  output logic                        o_image_done,
  output logic                        o_busy
);

  localparam int ROWW = IMAGE_SIZE * WIDTH;
  localparam int RL_W = $clog2(KERNEL_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRELOAD,
    S_READY,
    S_LOAD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ROWW-1:0]  r_bank [KERNEL_SIZE];
  logic [ROWW-1:0]  r_stage;
  logic [ROWW-1:0]  w_stage_nxt;
  logic [COL_W-1:0] r_col_idx;
  logic [RL_W-1:0]  r_rows_loaded;
  logic [ROW_W-1:0] r_img_row;
  logic             r_image_done;
  logic             r_ack_pre;
  logic             r_ack_load;

  logic w_busy;
  logic w_accept;
  logic w_last_col;
  logic w_commit;
  logic w_clear;
  logic w_last_pre;
  logic w_last_img;

  assign w_busy     = (r_state == S_PRELOAD) ||
                      (r_state == S_LOAD);
  assign w_accept   = i_pixel_valid && w_busy;
  assign w_last_col = (r_col_idx == COL_W'(IMAGE_SIZE - 1));
  assign w_commit   = w_accept && w_last_col;
  assign w_clear    = i_cmd_start &&
                      ((r_state == S_IDLE) ||
                       (r_state == S_READY));
  assign w_last_pre = (r_rows_loaded ==
                       RL_W'(KERNEL_SIZE - 1));
  assign w_last_img = (r_img_row ==
                       ROW_W'(IMAGE_SIZE - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start beats next, next ignored once image done
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_cmd_start) w_state_nxt = S_PRELOAD;
      end
      S_PRELOAD: begin
        if (w_commit && w_last_pre) w_state_nxt = S_READY;
      end
      S_READY: begin
        if (i_cmd_start)
          w_state_nxt = S_PRELOAD;
        else if (i_cmd_next && !r_image_done)
          w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_commit) w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    o_busy         = w_busy;
    o_pixel_ready  = w_busy;
    o_window_valid = (r_state == S_READY);
  end

  // Staging row with the incoming pixel merged into its column slot
  always_comb begin
    w_stage_nxt = r_stage;
    for (int c = 0; c < IMAGE_SIZE; c++) begin
      if (r_col_idx == COL_W'(c))
        w_stage_nxt[(IMAGE_SIZE-c)*WIDTH-1 -: WIDTH] = i_pixel_in;
    end
  end

  // Pixel capture, row commit and bank roll
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KERNEL_SIZE; i++) r_bank[i] <= '0;
      r_stage       <= '0;
      r_col_idx     <= '0;
      r_rows_loaded <= '0;
      r_img_row     <= '0;
      r_image_done  <= 1'b0;
    end else if (w_clear) begin
      for (int i = 0; i < KERNEL_SIZE; i++) r_bank[i] <= '0;
      r_stage       <= '0;
      r_col_idx     <= '0;
      r_rows_loaded <= '0;
      r_img_row     <= '0;
      r_image_done  <= 1'b0;
    end else if (w_accept) begin
      r_stage <= w_stage_nxt;
      if (w_last_col) begin
        for (int i = 0; i < KERNEL_SIZE - 1; i++)
          r_bank[i] <= r_bank[i+1];
        r_bank[KERNEL_SIZE-1] <= w_stage_nxt;
        r_col_idx <= '0;
        r_img_row <= r_img_row + ROW_W'(1);
        if (w_last_img) r_image_done <= 1'b1;
        if (r_state == S_PRELOAD)
          r_rows_loaded <= r_rows_loaded + RL_W'(1);
      end else begin
        r_col_idx <= r_col_idx + COL_W'(1);
      end
    end
  end

  // One-cycle acknowledge pulses after the completing commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_pre  <= 1'b0;
      r_ack_load <= 1'b0;
    end else begin
      r_ack_pre  <= (r_state == S_PRELOAD) &&
                    w_commit && w_last_pre;
      r_ack_load <= (r_state == S_LOAD) && w_commit;
    end
  end

  assign o_ack_preload_fin = r_ack_pre;
  assign o_ack_load_fin    = r_ack_load;
  assign o_image_done      = r_image_done;

  // Output row mux; bias has priority, out-of-range select reads zero
  always_comb begin
    o_data_out_bus = '0;
    if (i_bias_sel) begin
      o_data_out_bus = {IMAGE_SIZE{FLOAT32_ONE}};
    end else begin
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        if (i_row_sel == SEL_W'(k))
          o_data_out_bus = r_bank[k];
      end
    end
  end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Self-checking bench for conv_line_buffer.
// Scoreboard queue of expected rows drained on each acknowledge.
module tb_conv_line_buffer;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int K  = 3;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_start = 1'b0;
  logic          cmd_next = 1'b0;
  logic [W-1:0]  pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic [1:0]    row_sel = '0;
  logic          bias_sel = 1'b0;
  logic [BW-1:0] data_out_bus;
  logic          window_valid;
  logic          ack_pre;
  logic          ack_load;
  logic          image_done;
  logic          busy;

  conv_line_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .i_cmd_start       (cmd_start),
    .i_cmd_next        (cmd_next),
    .i_pixel_in        (pixel_in),
    .i_pixel_valid     (pixel_valid),
    .o_pixel_ready     (pixel_ready),
    .i_row_sel         (row_sel),
    .i_bias_sel        (bias_sel),
    .o_data_out_bus    (data_out_bus),
    .o_window_valid    (window_valid),
    .o_ack_preload_fin (ack_pre),
    .o_ack_load_fin    (ack_load),
    .o_image_done      (image_done),
    .o_busy            (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int acc_cnt = 0;
  int pre_cnt = 0;
  int load_cnt = 0;

  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] model [K];

  always @(negedge clk) begin
    if (pixel_valid && pixel_ready) acc_cnt++;
    if (ack_pre) pre_cnt++;
    if (ack_load) load_cnt++;
  end

  function automatic logic [BW-1:0] row_word(input int r);
    logic [BW-1:0] b;
    b = '0;
    for (int c = 0; c < N; c++)
      b[(N-c)*W-1 -: W] = W'(r * 16 + c);
    return b;
  endfunction

  task automatic pulse(input bit is_start);
    @(posedge clk); #1;
    if (is_start) cmd_start = 1'b1;
    else          cmd_next  = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    cmd_next  = 1'b0;
  endtask

  task automatic send_pix(input logic [W-1:0] p);
    bit ok;
    ok = 1'b0;
    pixel_in    = p;
    pixel_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (pixel_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: pixel %h never accepted", p);
    end
  endtask

  task automatic send_row(input int r, input bit gap);
    for (int c = 0; c < N; c++) begin
      send_pix(W'(r * 16 + c));
      if (gap && c != N - 1) begin
        @(posedge clk); #1;
      end
    end
    exp_q.push_back(row_word(r));
  endtask

  task automatic drain_model();
    while (exp_q.size() > 0) begin
      for (int i = 0; i < K - 1; i++) model[i] = model[i+1];
      model[K-1] = exp_q.pop_front();
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < K; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    clear_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({pixel_ready, window_valid, busy, ack_pre,
         ack_load, image_done} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000",
               {pixel_ready, window_valid, busy, ack_pre,
                ack_load, image_done});
    else n_pass++;
    for (int s = 0; s < 4; s++) begin
      row_sel = 2'(s);
      #1;
      n_total++;
      if (data_out_bus !== '0)
        $display("FAIL reset_bus%0d: got %h want 0",
                 s, data_out_bus);
      else n_pass++;
    end
  endtask

  task automatic check_banks(input string tag);
    for (int s = 0; s < K; s++) begin
      row_sel = 2'(s);
      #1;
      n_total++;
      if (data_out_bus !== model[s])
        $display("FAIL %s_bank%0d: got %h want %h",
                 tag, s, data_out_bus, model[s]);
      else n_pass++;
    end
  endtask

  task automatic test_preload(input string tag);
    int p0;
    pulse(1'b1);
    n_total++;
    if (busy !== 1'b1 || pixel_ready !== 1'b1)
      $display("FAIL %s_busy: got %b%b want 11",
               tag, busy, pixel_ready);
    else n_pass++;
    p0 = pre_cnt;
    for (int r = 0; r < K; r++) send_row(r, 1'b0);
    @(negedge clk);
    n_total++;
    if (ack_pre !== 1'b1 || ack_load !== 1'b0)
      $display("FAIL %s_ack_now: got %b%b want 10",
               tag, ack_pre, ack_load);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ack_pre !== 1'b0 || pre_cnt - p0 !== 1)
      $display("FAIL %s_ack_once: got ack=%b n=%0d want 0,1",
               tag, ack_pre, pre_cnt - p0);
    else n_pass++;
    n_total++;
    if ({window_valid, pixel_ready, image_done} !== 3'b100)
      $display("FAIL %s_ready: got %b want 100",
               tag, {window_valid, pixel_ready, image_done});
    else n_pass++;
    drain_model();
    check_banks(tag);
  endtask

  task automatic test_load_toggle();
    int a0, l0;
    pulse(1'b0);
    a0 = acc_cnt;
    l0 = load_cnt;
    send_row(3, 1'b1);
    @(negedge clk);
    n_total++;
    if (ack_load !== 1'b1 || window_valid !== 1'b1)
      $display("FAIL toggle_ack: got %b%b want 11",
               ack_load, window_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (acc_cnt - a0 !== N || load_cnt - l0 !== 1)
      $display("FAIL toggle_counts: got acc=%0d ack=%0d want 8,1",
               acc_cnt - a0, load_cnt - l0);
    else n_pass++;
    drain_model();
    check_banks("toggle");
  endtask

  task automatic test_until_done();
    int l0;
    for (int r = 4; r < N; r++) begin
      pulse(1'b0);
      n_total++;
      if (window_valid !== 1'b0 || busy !== 1'b1)
        $display("FAIL load%0d_state: got wv=%b busy=%b want 0,1",
                 r, window_valid, busy);
      else n_pass++;
      send_row(r, 1'b0);
      @(negedge clk);
      n_total++;
      if (image_done !== (r == N - 1))
        $display("FAIL done_row%0d: got %b want %b",
                 r, image_done, r == N - 1);
      else n_pass++;
    end
    drain_model();
    check_banks("done");
    l0 = load_cnt;
    pulse(1'b0);
    repeat (3) @(negedge clk);
    n_total++;
    if ({window_valid, pixel_ready, busy} !== 3'b100 ||
        load_cnt !== l0)
      $display("FAIL next_ignored: got %b ack=%0d want 100,0",
               {window_valid, pixel_ready, busy}, load_cnt - l0);
    else n_pass++;
  endtask

  task automatic test_bias();
    logic [BW-1:0] ones;
    ones = {N{32'h3F800000}};
    bias_sel = 1'b1;
    for (int s = 0; s < 4; s++) begin
      row_sel = 2'(s);
      #1;
      n_total++;
      if (data_out_bus !== ones)
        $display("FAIL bias_sel%0d: got %h want %h",
                 s, data_out_bus, ones);
      else n_pass++;
    end
    bias_sel = 1'b0;
    row_sel = 2'd3;
    #1;
    n_total++;
    if (data_out_bus !== '0)
      $display("FAIL rowsel3_zero: got %h want 0", data_out_bus);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int l0;
    pulse(1'b1);
    clear_model();
    n_total++;
    if (image_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL restart_clear: got done=%b busy=%b want 0,1",
               image_done, busy);
    else n_pass++;
    check_banks("restart");
    for (int r = 0; r < K; r++) send_row(r, 1'b0);
    drain_model();
    pulse(1'b0);
    l0 = load_cnt;
    for (int c = 0; c < 5; c++) send_pix(W'(3 * 16 + c));
    rst = 1'b1;
    #1;
    clear_model();
    n_total++;
    if ({busy, pixel_ready, window_valid, ack_load} !== 4'b0)
      $display("FAIL midrst_flags: got %b want 0000",
               {busy, pixel_ready, window_valid, ack_load});
    else n_pass++;
    check_banks("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (load_cnt !== l0)
      $display("FAIL midrst_noack: got %0d want 0", load_cnt - l0);
    else n_pass++;
    test_preload("clean");
  endtask

  initial begin
    test_reset();
    test_preload("pre");
    test_load_toggle();
    test_until_done();
    test_bias();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule
